// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, injected interrupt opcode and
// the interrupt-kind encoding used by the sequencer and instdecode.
package cpu_pkg;
    localparam int unsigned CYCW = 3;
    localparam int unsigned OPW  = 8;
    localparam logic [OPW-1:0] INT_OP = 8'h00;

    typedef enum logic [1:0] {
        INT_NONE = 2'd0,
        INT_CLR  = 2'd1,
        INT_NMI  = 2'd2,
        INT_IRQ  = 2'd3
    } int_kind_e;
endpackage

// File: rtl/int_arbiter.sv
// Interrupt arbiter: NMI edge detector/latch and boundary priority select.
// o_kind is the interrupt that the current cycle would take if it were an
// instruction boundary; the sequencer registers it on rcyc.
module int_arbiter
    import cpu_pkg::*;
#(
    parameter int NMI_EDGE = 1
) (
    input  logic      clk,
    input  logic      clr,
    input  logic      i_nmi,
    input  logic      i_irq,
    input  logic      i_irqdis,
    input  logic      i_take,
    output int_kind_e o_kind
);
    logic r_nmi_prev;
    logic r_nmi_lat;
    logic w_nmi_edge;
    logic w_take_nmi;

    assign w_nmi_edge = i_nmi & ~r_nmi_prev;

    // Priority: reset > latched NMI > unmasked IRQ. IRQ is level-only.
    always_comb begin
        o_kind = INT_NONE;
        if (clr)                     o_kind = INT_CLR;
        else if (r_nmi_lat)          o_kind = INT_NMI;
        else if (i_irq && !i_irqdis) o_kind = INT_IRQ;
    end

    assign w_take_nmi = i_take && (o_kind == INT_NMI);

    // NMI history and latch; a new edge in the taking cycle wins over clear.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_nmi_prev <= 1'b0;
            r_nmi_lat  <= 1'b0;
        end else begin
            r_nmi_prev <= i_nmi;
            if (NMI_EDGE != 0) begin
                if (w_nmi_edge)      r_nmi_lat <= 1'b1;
                else if (w_take_nmi) r_nmi_lat <= 1'b0;
            end else begin
                r_nmi_lat <= i_nmi;
            end
        end
    end
endmodule

// File: rtl/cycle_sequencer.sv
// Instruction register and cycle counter feeding instdecode. Steps the
// cycle on decoder requests and injects INT_OP when an interrupt is taken
// at an instruction boundary. All outputs come straight from registers.
module cycle_sequencer
    import cpu_pkg::*;
#(
    parameter int NMI_EDGE = 1
) (
    input  logic            clk,
    input  logic            clr,
    input  logic            irq,
    input  logic            nmi,
    input  logic            irqdis,
    input  logic [OPW-1:0]  dbin,
    input  logic            icyc,
    input  logic            rcyc,
    input  logic            scyc,
    output logic [OPW-1:0]  inst,
    output logic [CYCW-1:0] cycle,
    output logic            int_clr,
    output logic            int_nmi,
    output logic            int_irq,
    output logic            sync,
    output logic            seq_err
);
    logic [OPW-1:0]  r_inst;
    logic [CYCW-1:0] r_cycle;
    int_kind_e       r_kind;
    logic            r_sync;
    logic            r_err;

    int_kind_e       w_kind;
    logic [CYCW:0]   w_sum;

    int_arbiter #(
        .NMI_EDGE (NMI_EDGE)
    ) u_arb (
        .clk      (clk),
        .clr      (clr),
        .i_nmi    (nmi),
        .i_irq    (irq),
        .i_irqdis (irqdis),
        .i_take   (rcyc),
        .o_kind   (w_kind)
    );

    // Next cycle value with carry; scyc beats icyc, rcyc is handled apart.
    always_comb begin
        w_sum = {1'b0, r_cycle};
        if (scyc)      w_sum = {1'b0, r_cycle} + (CYCW+1)'(2);
        else if (icyc) w_sum = {1'b0, r_cycle} + (CYCW+1)'(1);
    end

    // Sequencer state: reset overrides, then rcyc > scyc > icyc.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_inst  <= INT_OP;
            r_cycle <= '0;
            r_kind  <= INT_CLR;
            r_sync  <= 1'b0;
            r_err   <= 1'b0;
        end else if (rcyc) begin
            r_cycle <= '0;
            r_kind  <= w_kind;
            r_inst  <= (w_kind == INT_NONE) ? dbin : INT_OP;
            r_sync  <= (w_kind == INT_NONE);
        end else if (scyc || icyc) begin
            r_cycle <= w_sum[CYCW-1:0];
            r_sync  <= 1'b0;
            if (w_sum[CYCW]) r_err <= 1'b1;
        end
    end

    assign inst    = r_inst;
    assign cycle   = r_cycle;
    assign int_clr = (r_kind == INT_CLR);
    assign int_nmi = (r_kind == INT_NMI);
    assign int_irq = (r_kind == INT_IRQ);
    assign sync    = r_sync;
    assign seq_err = r_err;
endmodule

// File: tb/tb_cycle_sequencer.sv
// Directed bench for cycle_sequencer: linear stimulus, hand-computed
// expectations checked with immediate assertions.
module tb_cycle_sequencer;
    logic       clk = 1'b0;
    logic       clr, irq, nmi, irqdis, icyc, rcyc, scyc;
    logic [7:0] dbin;
    logic [7:0] inst;
    logic [2:0] cycle;
    logic       int_clr, int_nmi, int_irq, sync, seq_err;

    int vectors = 0;
    int miscompares = 0;

    cycle_sequencer #(.NMI_EDGE(1)) dut (
        .clk(clk), .clr(clr), .irq(irq), .nmi(nmi), .irqdis(irqdis),
        .dbin(dbin), .icyc(icyc), .rcyc(rcyc), .scyc(scyc),
        .inst(inst), .cycle(cycle), .int_clr(int_clr), .int_nmi(int_nmi),
        .int_irq(int_irq), .sync(sync), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // inst, cycle, {int_clr,int_nmi,int_irq}, sync
    task automatic chk_state(input string tag, input logic [7:0] ei, input logic [2:0] ec,
                             input logic [2:0] ek, input logic es);
        chk({tag, ".inst"},  32'(inst), 32'(ei));
        chk({tag, ".cycle"}, 32'(cycle), 32'(ec));
        chk({tag, ".kind"},  32'({int_clr, int_nmi, int_irq}), 32'(ek));
        chk({tag, ".sync"},  32'(sync), 32'(es));
    endtask

    initial begin
        clr = 1; irq = 0; nmi = 0; irqdis = 0; icyc = 0; rcyc = 0; scyc = 0; dbin = 8'h00;
        tick();
        clr = 0;
        chk_state("reset", 8'h00, 3'd0, 3'b100, 1'b0);
        chk("reset.err", 32'(seq_err), 32'd0);

        // Reset sequence stepping
        icyc = 1;
        tick(); chk("rst_c1", 32'(cycle), 32'd1);
        tick(); chk("rst_c2", 32'(cycle), 32'd2);
        tick(); icyc = 0;
        chk_state("rst_c3", 8'h00, 3'd3, 3'b100, 1'b0);

        rcyc = 1; dbin = 8'hA9; tick(); rcyc = 0;
        chk_state("fetch_a9", 8'hA9, 3'd0, 3'b000, 1'b1);

        // scyc then icyc, then all three at once
        scyc = 1; tick(); scyc = 0;
        chk("scyc.cycle", 32'(cycle), 32'd2);
        chk("scyc.sync", 32'(sync), 32'd0);
        icyc = 1; tick(); icyc = 0;
        chk("icyc.cycle", 32'(cycle), 32'd3);
        icyc = 1; scyc = 1; rcyc = 1; dbin = 8'h4C; tick();
        icyc = 0; scyc = 0; rcyc = 0;
        chk_state("all3", 8'h4C, 3'd0, 3'b000, 1'b1);

        // NMI pulse mid-instruction at cycle 3
        icyc = 1; tick(); tick(); tick(); icyc = 0;
        chk("mid.cycle", 32'(cycle), 32'd3);
        nmi = 1; tick(); nmi = 0;
        chk("nmi_idle.cycle", 32'(cycle), 32'd3);
        rcyc = 1; dbin = 8'hEA; tick(); rcyc = 0;
        chk_state("nmi_take", 8'h00, 3'd0, 3'b010, 1'b0);
        icyc = 1; tick(); icyc = 0;
        chk_state("nmi_hold", 8'h00, 3'd1, 3'b010, 1'b0);
        rcyc = 1; tick(); rcyc = 0;
        chk_state("nmi_done", 8'hEA, 3'd0, 3'b000, 1'b1);

        // IRQ masking, IRQ taken, NMI beats IRQ
        irq = 1; irqdis = 1; rcyc = 1; dbin = 8'h11; tick();
        chk_state("irq_masked", 8'h11, 3'd0, 3'b000, 1'b1);
        irqdis = 0; tick();
        chk_state("irq_take", 8'h00, 3'd0, 3'b001, 1'b0);
        rcyc = 0; nmi = 1; tick(); nmi = 0;
        chk_state("irq_hold", 8'h00, 3'd0, 3'b001, 1'b0);
        rcyc = 1; tick(); rcyc = 0;
        chk_state("nmi_over_irq", 8'h00, 3'd0, 3'b010, 1'b0);
        irq = 0;

        // New NMI edge in the taking cycle re-latches
        nmi = 1; tick(); nmi = 0; tick();
        nmi = 1; rcyc = 1; tick(); nmi = 0;
        chk_state("nmi_take2", 8'h00, 3'd0, 3'b010, 1'b0);
        tick();
        chk_state("nmi_relatch", 8'h00, 3'd0, 3'b010, 1'b0);
        dbin = 8'h22; tick(); rcyc = 0;
        chk_state("nmi_clear", 8'h22, 3'd0, 3'b000, 1'b1);

        // Overflow: 7 icyc reach cycle 7, the 8th wraps and sets seq_err
        icyc = 1;
        for (int i = 0; i < 7; i++) tick();
        chk("ovf7.cycle", 32'(cycle), 32'd7);
        chk("ovf7.err", 32'(seq_err), 32'd0);
        tick(); icyc = 0;
        chk_state("ovf8", 8'h22, 3'd0, 3'b000, 1'b0);
        chk("ovf8.err", 32'(seq_err), 32'd1);
        rcyc = 1; dbin = 8'h33; tick(); rcyc = 0;
        chk("ovf_sticky.inst", 32'(inst), 32'h33);
        chk("ovf_sticky.err", 32'(seq_err), 32'd1);

        // scyc wrap from 7 (3 -> 5 -> 7 -> 1)
        icyc = 1; tick(); tick(); tick(); icyc = 0;
        scyc = 1; tick(); tick(); scyc = 0;
        chk("scyc7.cycle", 32'(cycle), 32'd7);
        scyc = 1; tick(); scyc = 0;
        chk("scyc_wrap.cycle", 32'(cycle), 32'd1);

        // clr at cycle 4 of an IRQ sequence, with an NMI latched
        irq = 1; rcyc = 1; tick(); rcyc = 0; irq = 0;
        chk("irq2.kind", 32'({int_clr, int_nmi, int_irq}), 32'b001);
        icyc = 1; tick(); tick(); tick(); nmi = 1; tick(); icyc = 0; nmi = 0;
        chk_state("irq2_c4", 8'h00, 3'd4, 3'b001, 1'b0);
        clr = 1; tick(); clr = 0;
        chk_state("clr_mid", 8'h00, 3'd0, 3'b100, 1'b0);
        chk("clr_mid.err", 32'(seq_err), 32'd0);
        rcyc = 1; dbin = 8'h55; tick(); rcyc = 0;
        chk_state("post_clr", 8'h55, 3'd0, 3'b000, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/cycle_sequencer.md
Name: cycle_sequencer

Overview:
- Owns the instruction register and the 3-bit cycle counter that drive instdecode's `inst` and `cycle` inputs.
- Consumes the decoder's `icyc`, `rcyc` and `scyc` step requests.
- Arbitrates reset, NMI and IRQ at instruction boundaries. When an interrupt is taken, it forces opcode 8'h00 into the instruction register and presents one-hot interrupt-kind flags to the decoder.
- Sits between the data-bus input latch, the status register I flag, and instdecode.

Parameters:
- CYCW, 3, cycle counter width.
- OPW, 8, opcode width.
- INT_OP, 8'h00, opcode injected for any taken interrupt or reset.
- NMI_EDGE, 1. 1 = NMI is rising-edge latched; 0 = NMI is level-sensitive.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- irq  in  1  interrupt request, level, active-high.
- nmi  in  1  non-maskable interrupt, active-high.
- irqdis  in  1  status register I flag; 1 masks irq.
- dbin  in  OPW  data bus value; opcode source at an instruction boundary.
- icyc  in  1  decoder request: advance cycle by 1.
- rcyc  in  1  decoder request: instruction done; go to cycle 0 with the next opcode.
- scyc  in  1  decoder request: skip one cycle (advance by 2).
- inst  out  OPW  current opcode to the decoder.
- cycle  out  CYCW  current cycle to the decoder.
- int_clr  out  1  reset sequence in progress.
- int_nmi  out  1  NMI sequence in progress.
- int_irq  out  1  IRQ sequence in progress.
- sync  out  1  high in cycle 0 of a normally fetched (non-injected) opcode.
- seq_err  out  1  sticky cycle-overflow flag.

Behaviour:
- Reset (clr=1 at a clock edge):
  - inst=INT_OP, cycle=0, int_clr=1, int_nmi=0, int_irq=0, seq_err=0, sync=0.
  - NMI latch and edge history are cleared.
  - Reset overrides every other input, including mid-instruction and mid-interrupt.
- Step priority when several requests are active in one cycle: rcyc > scyc > icyc. No request: cycle and inst hold.
- icyc:
  - cycle <= cycle+1.
  - At cycle=7, cycle wraps to 0, seq_err <= 1 (sticky until clr), and inst is unchanged.
- scyc:
  - cycle <= cycle+2, modulo 8.
  - A wrap sets seq_err.
- rcyc (instruction boundary):
  - cycle <= 0, and interrupt flags are reselected with priority int_clr-pending > NMI latch > (irq & ~irqdis).
  - Interrupt taken: inst <= INT_OP; exactly one of int_clr/int_nmi/int_irq = 1; sync=0.
  - No interrupt: inst <= dbin; all int_* = 0; sync=1 for that cycle 0.
- Reset flag: int_clr from clr stays high through the whole reset sequence and clears at the reset sequence's terminating rcyc, unless clr is reasserted.
- NMI latch (NMI_EDGE=1):
  - Set on an nmi 0->1 transition.
  - Cleared at the rcyc that takes the NMI.
  - An edge arriving in that same cycle re-sets the latch; set wins over clear.
  - An edge during an NMI/IRQ sequence stays latched and is serviced at the next boundary.
- NMI_EDGE=0: the latch simply follows nmi.
- IRQ: not latched. irq must be high, with irqdis low, in the rcyc cycle for it to be taken.
- Latency and hold:
  - Every request takes effect on the next rising edge; outputs are registered with no combinational path from inputs to outputs.
  - Interrupt-kind flags are held constant from the boundary that takes the interrupt to the next rcyc.
- sync deasserts on the first icyc or scyc after the boundary.

Decomposition:
- Shared package cpu_pkg: CYCW, OPW, INT_OP, and an interrupt-kind enum {INT_NONE, INT_CLR, INT_NMI, INT_IRQ}. instdecode also uses this package.
- One sub-module: int_arbiter. It holds the NMI edge detector and latch and performs the priority selection, outputting the kind for the boundary.
- The counter and instruction register stay in the top level.

Test Plan:
- Reset then three icyc pulses -> inst=00, int_clr=1, cycle 0,1,2,3. Then rcyc with dbin=8'hA9 -> inst=A9, cycle=0, sync=1, int_clr=0.
- From cycle=0, scyc then icyc -> cycle 2 then 3. icyc, scyc and rcyc together -> cycle=0 (rcyc wins).
- One-cycle nmi pulse during mid-instruction cycle 3, then rcyc -> inst=00, int_nmi=1, sync=0. At the following rcyc with nmi low -> normal fetch, int_nmi=0.
- irq=1 and irqdis=1 at rcyc -> normal fetch of dbin. irq=1 and irqdis=0 at next rcyc -> int_irq=1. nmi edge and irq together -> int_nmi wins and int_irq stays 0.
- Eight consecutive icyc from cycle 0 -> cycle returns to 0 and seq_err=1. seq_err stays 1 across rcyc and clears only on clr.
- clr asserted at cycle 4 of an IRQ sequence -> next edge inst=00, cycle=0, int_clr=1, int_irq=0, and the NMI latch is cleared.
